// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
// Base logic/add/compare ops finish one cycle after accept. MULLO/MULHU use
// an iterative shift-add multiplier. DIVU/REMU use a restoring divider.
// Optional divider: define ALU_MC_DIV_EN to build it. Without the macro,
// DIVU/REMU respond like reserved opcodes.
// Only one operation is in flight at a time.
module alu_mc #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            ALUop,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Overflow,
    output logic                  CarryOut,
    output logic                  Zero,
    output logic                  Err
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2*W-1:0]  acc_q;      // {hi, lo}: product, or {remainder, quotient}
    logic [W-1:0]    opnd_q;     // multiplicand for MUL, divisor for DIV
    logic            sel_hi_q;   // MULHU / REMU select the upper half
    logic            in_ready_q;
    logic            out_valid_q;
    logic [W-1:0]    result_q;
    logic            ovf_q;
    logic            co_q;
    logic            zero_q;
    logic            err_q;

    logic            is_sub_s;
    logic [W-1:0]    addend_s;
    logic [W:0]      sum_s;
    logic            carry_flag_s;
    logic            add_ovf_s;
    logic [W-1:0]    base_res_s;
    logic            base_ovf_s;
    logic            base_co_s;
    logic            base_err_s;
    logic [W:0]      mul_sum_s;
    logic [2*W-1:0]  mul_next_s;
    logic [W-1:0]    mul_res_s;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign Overflow  = ovf_q;
    assign CarryOut  = co_q;
    assign Zero      = zero_q;
    assign Err       = err_q;

    // Shared adder: subtract-style ops add the inverted B plus one.
    always_comb begin
        case (ALUop)
            4'b0110, 4'b0111, 4'b0011: is_sub_s = 1'b1;
            default:                   is_sub_s = 1'b0;
        endcase
        addend_s     = is_sub_s ? ~B : B;
        sum_s        = {1'b0, A} + {1'b0, addend_s} + {{W{1'b0}}, is_sub_s};
        carry_flag_s = sum_s[W] ^ is_sub_s;
        add_ovf_s    = (A[W-1] == addend_s[W-1]) && (sum_s[W-1] != A[W-1]);
    end

    // Single-cycle op result and flags, taken at the accept edge.
    always_comb begin
        base_res_s = {W{1'b0}};
        base_ovf_s = 1'b0;
        base_co_s  = 1'b0;
        base_err_s = 1'b0;
        case (ALUop)
            4'b0000: base_res_s = A & B;
            4'b0001: base_res_s = A | B;
            4'b0100: base_res_s = A ^ B;
            4'b0101: base_res_s = ~(A | B);
            4'b0010, 4'b0110: begin
                base_res_s = sum_s[W-1:0];
                base_ovf_s = add_ovf_s;
                base_co_s  = carry_flag_s;
            end
            4'b0111: begin
                base_res_s = {{(W-1){1'b0}}, sum_s[W-1] ^ add_ovf_s};
                base_ovf_s = add_ovf_s;
                base_co_s  = carry_flag_s;
            end
            4'b0011: begin
                base_res_s = {{(W-1){1'b0}}, carry_flag_s};
                base_ovf_s = add_ovf_s;
                base_co_s  = carry_flag_s;
            end
            default: base_err_s = 1'b1;
        endcase
    end

    // One shift-add multiply step: add the multiplicand on a set LSB, then shift right.
    always_comb begin
        mul_sum_s  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
        mul_next_s = {mul_sum_s, acc_q[W-1:1]};
        mul_res_s  = sel_hi_q ? mul_next_s[2*W-1:W] : mul_next_s[W-1:0];
    end

`ifdef ALU_MC_DIV_EN
    logic [W:0]      div_shift_s;
    logic [W:0]      div_diff_s;
    logic            div_ge_s;
    logic [W-1:0]    div_rem_s;
    logic [2*W-1:0]  div_next_s;
    logic [W-1:0]    div_res_s;

    // One restoring divide step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        div_shift_s = acc_q[2*W-1:W-1];
        div_diff_s  = div_shift_s - {1'b0, opnd_q};
        div_ge_s    = ~div_diff_s[W];
        div_rem_s   = div_ge_s ? div_diff_s[W-1:0] : div_shift_s[W-1:0];
        div_next_s  = {div_rem_s, acc_q[W-2:0], div_ge_s};
        div_res_s   = sel_hi_q ? div_next_s[2*W-1:W] : div_next_s[W-1:0];
    end
`endif

    // Control FSM with registered handshake, result and flag outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            acc_q       <= {(2*W){1'b0}};
            opnd_q      <= {W{1'b0}};
            sel_hi_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= {W{1'b0}};
            ovf_q       <= 1'b0;
            co_q        <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        cnt_q      <= {CW{1'b0}};
                        sel_hi_q   <= ALUop[0];
                        case (ALUop)
                            4'b1000, 4'b1001: begin
                                opnd_q  <= A;
                                acc_q   <= {{W{1'b0}}, B};
                                state_q <= ST_MUL;
                            end
`ifdef ALU_MC_DIV_EN
                            4'b1010, 4'b1011: begin
                                if (B == {W{1'b0}}) begin
                                    result_q    <= ALUop[0] ? A : {W{1'b1}};
                                    zero_q      <= ALUop[0] ? (A == {W{1'b0}}) : 1'b0;
                                    ovf_q       <= 1'b0;
                                    co_q        <= 1'b0;
                                    err_q       <= 1'b0;
                                    out_valid_q <= 1'b1;
                                    state_q     <= ST_DONE;
                                end else begin
                                    opnd_q  <= B;
                                    acc_q   <= {{W{1'b0}}, A};
                                    state_q <= ST_DIV;
                                end
                            end
`endif
                            default: begin
                                result_q    <= base_res_s;
                                zero_q      <= (base_res_s == {W{1'b0}});
                                ovf_q       <= base_ovf_s;
                                co_q        <= base_co_s;
                                err_q       <= base_err_s;
                                out_valid_q <= 1'b1;
                                state_q     <= ST_DONE;
                            end
                        endcase
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_MUL: begin
                    acc_q <= mul_next_s;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        result_q    <= mul_res_s;
                        zero_q      <= (mul_res_s == {W{1'b0}});
                        ovf_q       <= 1'b0;
                        co_q        <= 1'b0;
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        state_q <= ST_MUL;
                    end
                end
`ifdef ALU_MC_DIV_EN
                ST_DIV: begin
                    acc_q <= div_next_s;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        result_q    <= div_res_s;
                        zero_q      <= (div_res_s == {W{1'b0}});
                        ovf_q       <= 1'b0;
                        co_q        <= 1'b0;
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        state_q <= ST_DIV;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc (DATA_WIDTH=32).
// The reference model works from plain arithmetic. It uses signed range
// checks, 64-bit products and the / and % operators.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUop;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        Overflow;
    logic        CarryOut;
    logic        Zero;
    logic        Err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        co;
        logic        zero;
        logic        err;
        int          lat;
    } exp_t;

    alu_mc #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUop(ALUop), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .Overflow(Overflow), .CarryOut(CarryOut), .Zero(Zero), .Err(Err)
    );

    always #5 clk = ~clk;

    function automatic logic sovf(input longint s);
        return (s != longint'($signed(s[31:0])));
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa;
        longint sb;
        logic [32:0] c;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.res = 32'd0; e.ovf = 1'b0; e.co = 1'b0; e.err = 1'b0; e.lat = 1;
        case (op)
            4'h0: e.res = a & b;
            4'h1: e.res = a | b;
            4'h4: e.res = a ^ b;
            4'h5: e.res = ~(a | b);
            4'h2: begin
                e.res = a + b;
                c = {1'b0, a} + {1'b0, b};
                e.co = c[32];
                e.ovf = sovf(sa + sb);
            end
            4'h6, 4'h7, 4'h3: begin
                e.co = (a < b);
                e.ovf = sovf(sa - sb);
                if (op == 4'h6)      e.res = a - b;
                else if (op == 4'h7) e.res = (sa < sb) ? 32'd1 : 32'd0;
                else                 e.res = (a < b) ? 32'd1 : 32'd0;
            end
            4'h8, 4'h9: begin
                p = 64'(a) * 64'(b);
                e.res = (op == 4'h8) ? p[31:0] : p[63:32];
                e.lat = 33;
            end
`ifdef ALU_MC_DIV_EN
            4'hA, 4'hB: begin
                if (b == 32'd0) begin
                    e.res = (op == 4'hA) ? 32'hFFFF_FFFF : a;
                end else begin
                    e.res = (op == 4'hA) ? (a / b) : (a % b);
                    e.lat = 33;
                end
            end
`endif
            default: e.err = 1'b1;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, check latency/result/flags, optionally stall the consumer.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
        exp_t e;
        int n;
        int lat;
        e = model(op, a, b);
        out_ready = (stall == 0);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1; ALUop = op; A = a; B = b;
        @(posedge clk); #1;
        in_valid = 1'b0; A = $urandom; B = $urandom; ALUop = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk($sformatf("latency op%0h", op), 64'(lat), 64'(e.lat));
        chk($sformatf("result op%0h %h,%h", op, a, b), 64'(Result), 64'(e.res));
        chk("overflow", 64'(Overflow), 64'(e.ovf));
        chk("carryout", 64'(CarryOut), 64'(e.co));
        chk("zero", 64'(Zero), 64'(e.zero));
        chk("err", 64'(Err), 64'(e.err));
        chk("busy_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("held_valid", 64'(out_valid), 64'd1);
            chk("held_result", 64'(Result), 64'(e.res));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("valid_cleared", 64'(out_valid), 64'd0);
        chk("ready_after", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int cnt;
        logic [3:0] rop;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n = 1'b0; in_valid = 1'b0; ALUop = 4'd0; A = 32'd0; B = 32'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_result", 64'(Result), 64'd0);
        chk("rst_flags", 64'({Overflow, CarryOut, Zero, Err}), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Reset in the middle of a multiply discards it.
        in_valid = 1'b1; ALUop = 4'b1000; A = 32'hFFFF_FFFF; B = 32'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        chk("no_stale_result", 64'(cnt), 64'd0);
        chk("midrst_ready_after", 64'(in_ready), 64'd1);
        chk("midrst_result", 64'(Result), 64'd0);

        // Directed base ops, multiply, divide and reserved cases.
        do_op(4'b0010, 32'h7FFF_FFFF, 32'd1, 0);
        do_op(4'b0110, 32'd0, 32'd1, 0);
        do_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
        do_op(4'b0011, 32'hFFFF_FFFF, 32'd1, 0);
        do_op(4'b0101, 32'd0, 32'd0, 0);
        do_op(4'b0000, 32'hF0F0_1234, 32'h0F0F_4321, 1);
        do_op(4'b1000, 32'hFFFF_FFFF, 32'd2, 0);
        do_op(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        do_op(4'b1010, 32'd100, 32'd7, 0);
        do_op(4'b1011, 32'd100, 32'd7, 0);
        do_op(4'b1010, 32'h1234_5678, 32'd0, 0);
        do_op(4'b1011, 32'd5, 32'd0, 0);
        do_op(4'b1100, 32'd9, 32'd9, 0);
        do_op(4'b0010, 32'd1, 32'd1, 0);

        // Backpressure: result held, a waiting second op is accepted only after release.
        out_ready = 1'b0;
        in_valid = 1'b1; ALUop = 4'b0010; A = 32'd3; B = 32'd4;
        @(posedge clk); #1;
        A = 32'd1; B = 32'd1;
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_result", 64'(Result), 64'd7);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_result", 64'(Result), 64'd7);
            chk("bp_hold_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_second_valid", 64'(out_valid), 64'd1);
        chk("bp_second_result", 64'(Result), 64'd2);
        @(posedge clk); #1;
        chk("bp_second_done", 64'(out_valid), 64'd0);

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
            do_op(rop, ra, rb, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
